// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encodings for mod_counter
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // Reserved encoding falls back to wrap behaviour.
  function automatic logic is_wrap_mode(mode_t m);
    return (m != MODE_SAT) && (m != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control/status bundle between a counter user and mod_counter
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  import counter_pkg::*;

  logic             ctrl;
  logic             up_dn;
  mode_t            mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_pulse;
  logic             done;

  modport master (
    output ctrl, up_dn, mode, load, load_val,
    input  count, tc, wrap_pulse, done
  );

  modport slave (
    input  ctrl, up_dn, mode, load, load_val,
    output count, tc, wrap_pulse, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled cycles into one tick every PRESCALE
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic ctrl,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;

  assign tick = ctrl && (pre_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
    end else if (ctrl) begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter with wrap, saturate and one-shot modes
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input logic           clk,
  input logic           reset,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             tick;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (bus.load),
    .ctrl  (bus.ctrl),
    .tick  (tick)
  );

  assign terminal       = bus.up_dn ? MAX_VAL : '0;
  assign bus.tc         = (count_q == terminal);
  assign bus.count      = count_q;
  assign bus.done       = done_q;
  assign bus.wrap_pulse = wrap_q;

  // A tick at the terminal value never steps past the range; the mode decides what happens.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      done_d  = 1'b0;
    end else if (tick && !done_q) begin
      if (!bus.tc) begin
        count_d = bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else if (bus.mode == MODE_ONESHOT) begin
        done_d = 1'b1;
      end else if (is_wrap_mode(bus.mode)) begin
        count_d = bus.up_dn ? '0 : MAX_VAL;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for mod_counter across four configurations
module tb_mod_counter;
  import counter_pkg::*;

  localparam int NI = 4;

  typedef struct {
    int cnt;
    int pre;
    bit wrap;
    bit done;
  } mstate_t;

  typedef struct {
    int cnt;
    bit tc;
    bit wrap;
    bit done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctrl = 1'b0;
  logic       up_dn = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;

  int mods[NI]   = '{10, 10, 10, 7};
  int pres[NI]   = '{1, 3, 4, 2};
  int widths[NI] = '{8, 8, 8, 3};

  mstate_t st[NI];
  exp_t    q[NI][$];

  logic [7:0] act_count[NI];
  logic       act_tc[NI];
  logic       act_wrap[NI];
  logic       act_done[NI];

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(8)) if0 ();
  mod_counter_if #(.WIDTH(8)) if1 ();
  mod_counter_if #(.WIDTH(8)) if2 ();
  mod_counter_if #(.WIDTH(3)) if3 ();

  mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  mod_counter #(.WIDTH(3), .MODULUS(7),  .PRESCALE(2)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign if0.ctrl = ctrl;  assign if0.up_dn = up_dn;  assign if0.mode = mode_t'(mode);
  assign if0.load = load;  assign if0.load_val = load_val;
  assign if1.ctrl = ctrl;  assign if1.up_dn = up_dn;  assign if1.mode = mode_t'(mode);
  assign if1.load = load;  assign if1.load_val = load_val;
  assign if2.ctrl = ctrl;  assign if2.up_dn = up_dn;  assign if2.mode = mode_t'(mode);
  assign if2.load = load;  assign if2.load_val = load_val;
  assign if3.ctrl = ctrl;  assign if3.up_dn = up_dn;  assign if3.mode = mode_t'(mode);
  assign if3.load = load;  assign if3.load_val = load_val[2:0];

  assign act_count[0] = if0.count;  assign act_tc[0] = if0.tc;
  assign act_wrap[0]  = if0.wrap_pulse;  assign act_done[0] = if0.done;
  assign act_count[1] = if1.count;  assign act_tc[1] = if1.tc;
  assign act_wrap[1]  = if1.wrap_pulse;  assign act_done[1] = if1.done;
  assign act_count[2] = if2.count;  assign act_tc[2] = if2.tc;
  assign act_wrap[2]  = if2.wrap_pulse;  assign act_done[2] = if2.done;
  assign act_count[3] = {5'd0, if3.count};  assign act_tc[3] = if3.tc;
  assign act_wrap[3]  = if3.wrap_pulse;  assign act_done[3] = if3.done;

  // Reference: a counter in 0..m-1 that advances once per p enabled cycles.
  function automatic mstate_t model_next(mstate_t s, int m, int p, int w, bit rst, bit ld,
                                         int lv, bit en, bit up, int md);
    mstate_t n;
    int v;
    n = s;
    n.wrap = 1'b0;
    if (rst) begin
      n.cnt = 0; n.pre = 0; n.done = 1'b0;
      return n;
    end
    if (ld) begin
      v = lv % (1 << w);
      n.cnt = (v < m) ? v : m - 1;
      n.pre = 0; n.done = 1'b0;
      return n;
    end
    if (!en) return n;
    n.pre = s.pre + 1;
    if (n.pre < p) return n;
    n.pre = 0;
    if (s.done) return n;
    if (up ? (s.cnt < m - 1) : (s.cnt > 0)) begin
      n.cnt = up ? s.cnt + 1 : s.cnt - 1;
    end else if (md == 2) begin
      n.done = 1'b1;
    end else if (md != 1) begin
      n.cnt = up ? 0 : m - 1;
      n.wrap = 1'b1;
    end
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(bit rst, bit ld, int lv, bit en, bit up, int md);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    load     = ld;
    load_val = 8'(lv);
    ctrl     = en;
    up_dn    = up;
    mode     = 2'(md);
    for (int i = 0; i < NI; i++) begin
      st[i]  = model_next(st[i], mods[i], pres[i], widths[i], rst, ld, lv, en, up, md);
      e.cnt  = st[i].cnt;
      e.tc   = up ? (st[i].cnt == mods[i] - 1) : (st[i].cnt == 0);
      e.wrap = st[i].wrap;
      e.done = st[i].done;
      q[i].push_back(e);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          check($sformatf("dut%0d_count", i), 32'(act_count[i]), 32'(e.cnt));
          check($sformatf("dut%0d_tc", i),    32'(act_tc[i]),    32'(e.tc));
          check($sformatf("dut%0d_wrap", i),  32'(act_wrap[i]),  32'(e.wrap));
          check($sformatf("dut%0d_done", i),  32'(act_done[i]),  32'(e.done));
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < NI; i++) st[i] = '{cnt: 0, pre: 0, wrap: 1'b0, done: 1'b0};

    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 5, 1, 1, 0);

    for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 1, 0);
    settle();
    check("wrap_up_end_count", 32'(act_count[0]), 32'd2);

    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 0, 0);

    step(0, 1, 8, 0, 1, 1);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 1, 1, 1);

    step(0, 1, 7, 0, 1, 2);
    for (int c = 0; c < 30; c++) step(0, 0, 0, 1, 1, 2);
    settle();
    check("oneshot_frozen_count", 32'(act_count[1]), 32'd9);
    check("oneshot_done", 32'(act_done[1]), 32'd1);
    step(0, 1, 2, 0, 1, 2);
    for (int c = 0; c < 10; c++) step(0, 0, 0, 1, 1, 2);

    step(0, 1, 0, 0, 1, 0);
    for (int c = 0; c < 2; c++) step(0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 6; c++) step(0, 0, 0, 1, 1, 0);
    step(0, 1, 200, 1, 1, 0);
    settle();
    check("load_clamp_count", 32'(act_count[2]), 32'd9);

    step(0, 1, 5, 0, 1, 0);
    step(1, 1, 9, 1, 1, 2);
    settle();
    check("reset_over_load_count", 32'(act_count[0]), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 255),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) check($sformatf("dut%0d_queue_drained", i), 32'(q[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, count register width in bits (1..32).
REQ-002 Parameter MODULUS, default 256, count range 0..MODULUS-1; SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter PRESCALE, default 1, number of enabled cycles per count step (1..65535).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ctrl  input  1  count enable; prescaler and count advance only while high.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-009 load  input  1  synchronous load of load_val.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 count  output  WIDTH  registered count value.
REQ-012 tc  output  1  combinational: high when count equals terminal for current up_dn (MODULUS-1 up, 0 down).
REQ-013 wrap_pulse  output  1  registered one-cycle pulse on wrap.
REQ-014 done  output  1  registered one-shot completion flag.

Function
REQ-015 Priority per cycle: reset > load > count step > hold.
REQ-016 Load: count <= min(load_val, MODULUS-1); prescaler <= 0; done <= 0; wrap_pulse <= 0; load applies regardless of ctrl.
REQ-017 Prescaler: while ctrl=1 it increments each cycle; tick asserted in cycle where prescaler == PRESCALE-1, prescaler then returns to 0; ctrl=0 holds prescaler; PRESCALE=1 gives tick every enabled cycle.
REQ-018 On tick with count != terminal: count +1 (up) or -1 (down), wrap_pulse <= 0.
REQ-019 On tick with count == terminal, wrap mode: count <= 0 (up) or MODULUS-1 (down); wrap_pulse <= 1 next cycle.
REQ-020 On tick with count == terminal, saturate mode: count holds; wrap_pulse stays 0.
REQ-021 On tick with count == terminal, one-shot mode: count holds; done <= 1.
REQ-022 While done=1, ticks SHALL not change count (any mode) until load or reset clears done.
REQ-023 wrap_pulse SHALL be 0 on every cycle not immediately following a wrap event; never high two consecutive cycles unless wraps occur on consecutive ticks (PRESCALE=1, MODULUS=2 edge case permitted).
REQ-024 up_dn and mode changes take effect at the next tick; no stored direction state.
REQ-025 Count SHALL never leave 0..MODULUS-1, including non-power-of-two MODULUS.
REQ-026 Latency: count changes one cycle after the enabled edge producing a tick; tc follows count combinationally.

Reset
REQ-027 Reset high at a rising edge: count=0, prescaler=0, wrap_pulse=0, done=0, overriding load and ctrl.
REQ-028 Reset mid-count or mid-prescale SHALL discard partial prescale progress; first tick after release needs a full PRESCALE enabled cycles.

Structure
REQ-029 Shared package counter_pkg SHALL hold mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and mode typedef.
REQ-030 Prescaler SHALL be sub-module tick_prescaler (ports clk, reset, clear, ctrl, tick; parameter PRESCALE).
REQ-031 Terminal-value compare and next-count logic stay in mod_counter.

Verification
REQ-032 WIDTH=8, MODULUS=10, PRESCALE=1, wrap, up, ctrl=1 from reset for 12 cycles -> count 1..9,0,1,2; wrap_pulse high exactly the cycle after 9->0.
REQ-033 Same config, down from reset -> count 9,8,...; first step 0->9 with wrap_pulse; tc high while count=0.
REQ-034 Saturate, up, load_val=8 then run 5 cycles -> count 8,9,9,9,9; wrap_pulse never high.
REQ-035 One-shot, PRESCALE=3, up, load_val=7 -> count steps every 3 enabled cycles to 9, done=1 on next tick, count frozen; load_val=2 clears done and restarts.
REQ-036 ctrl toggled off for 5 cycles mid-prescale with PRESCALE=4 -> prescaler holds, tick resumes after remaining enabled cycles; load_val=200 with MODULUS=10 -> count=9.
REQ-037 Reset asserted with load=1 and ctrl=1 while count=5 -> next cycle count=0, done=0, wrap_pulse=0.
